// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60 defaults), derived totals and the
// per-axis segment classifier used by both counter axes.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam bit H_POL_DEF     = 1'b0;
  localparam bit V_POL_DEF     = 1'b0;
  localparam int HW_DEF        = 10;
  localparam int VW_DEF        = 10;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  typedef enum logic [1:0] {
    SEG_DISPLAY,
    SEG_FRONT,
    SEG_SYNC,
    SEG_BACK
  } axis_seg_e;

  // Segments are laid out display, front porch, sync, back porch along an axis.
  function automatic axis_seg_e seg_of(int pos, int display, int front, int sync);
    if (pos < display)                     return SEG_DISPLAY;
    else if (pos < display + front)        return SEG_FRONT;
    else if (pos < display + front + sync) return SEG_SYNC;
    else                                   return SEG_BACK;
  endfunction

endpackage

// File: rtl/vga_timing_gen_axis.sv
// vga_axis_counter: one timing axis (count, wrap, sync window, active window).
// Sync is registered from the next count so it lines up with pos_o.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int DISPLAY = H_DISPLAY_DEF,
  parameter int FRONT   = H_FRONT_DEF,
  parameter int SYNC    = H_SYNC_DEF,
  parameter int BACK    = H_BACK_DEF,
  parameter bit POL     = H_POL_DEF,
  parameter int W       = HW_DEF
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         adv_i,
  output logic [W-1:0] pos_o,
  output logic         wrap_o,
  output logic         sync_o,
  output logic         nxt_active_o
);

  localparam int TOTAL = DISPLAY + FRONT + SYNC + BACK;

  if (longint'(TOTAL) > (longint'(1) << W)) begin : g_width_chk
    $fatal(1, "vga_axis_counter: total %0d does not fit in %0d bits", TOTAL, W);
  end

  logic [W-1:0] pos_p1;
  logic [W-1:0] nxt_pos;
  logic         sync_p1;
  axis_seg_e    nxt_seg;

  assign wrap_o = adv_i && (pos_p1 == W'(TOTAL - 1));

  always_comb begin
    nxt_pos = pos_p1;
    if (wrap_o)     nxt_pos = '0;
    else if (adv_i) nxt_pos = pos_p1 + W'(1);
  end

  assign nxt_seg      = seg_of(int'(nxt_pos), DISPLAY, FRONT, SYNC);
  assign nxt_active_o = (nxt_seg == SEG_DISPLAY);

  // stage p1: count and sync decode registered together
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pos_p1  <= '0;
      sync_p1 <= ~POL;
    end else begin
      pos_p1  <= nxt_pos;
      sync_p1 <= (nxt_seg == SEG_SYNC) ? POL : ~POL;
    end
  end

  assign pos_o  = pos_p1;
  assign sync_o = sync_p1;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal/vertical counters, syncs, display enable.
// Define VGA_TIMING_STROBE_EN to enable the line_start_o/frame_start_o strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter bit H_POL     = H_POL_DEF,
  parameter bit V_POL     = V_POL_DEF,
  parameter int HW        = HW_DEF,
  parameter int VW        = VW_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          pix_ce_i,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          display_on_o,
  output logic [HW-1:0] hpos_o,
  output logic [VW-1:0] vpos_o,
  output logic          line_start_o,
  output logic          frame_start_o
);

  logic h_wrap;
  logic h_nxt_active;
  logic v_nxt_active;
  logic unused_v_wrap;
  logic de_p1;

  vga_axis_counter #(
    .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK),
    .POL(H_POL), .W(HW)
  ) u_h (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .adv_i       (pix_ce_i),
    .pos_o       (hpos_o),
    .wrap_o      (h_wrap),
    .sync_o      (hsync_o),
    .nxt_active_o(h_nxt_active)
  );

  // The vertical axis steps only on the cycle the line wraps.
  vga_axis_counter #(
    .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK),
    .POL(V_POL), .W(VW)
  ) u_v (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .adv_i       (h_wrap),
    .pos_o       (vpos_o),
    .wrap_o      (unused_v_wrap),
    .sync_o      (vsync_o),
    .nxt_active_o(v_nxt_active)
  );

  // stage p1: display enable registered from the next-count decode of both axes
  always_ff @(posedge clk_i) begin
    if (rst_i) de_p1 <= 1'b1;
    else       de_p1 <= h_nxt_active && v_nxt_active;
  end

  assign display_on_o = de_p1;

`ifdef VGA_TIMING_STROBE_EN
  // Strobe on the advancing cycle at column 0, so a stall cannot stretch it
  // and the first enabled cycle after reset still produces one.
  assign line_start_o  = pix_ce_i && !rst_i && (hpos_o == '0);
  assign frame_start_o = line_start_o && (vpos_o == '0);
`else
  assign line_start_o  = 1'b0;
  assign frame_start_o = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameter sets driven in lockstep against a
// linear-index frame model, plus a vector table and corner-case sequences.
module tb_vga_timing_gen;

`ifdef VGA_TIMING_STROBE_EN
  localparam bit STRB = 1'b1;
`else
  localparam bit STRB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  logic        hs_d, vs_d, de_d, ls_d, fs_d;
  logic [9:0]  hp_d, vp_d;
  logic        hs_s, vs_s, de_s, ls_s, fs_s;
  logic [3:0]  hp_s, vp_s;
  logic        hs_p, vs_p, de_p, ls_p, fs_p;
  logic [10:0] hp_p;
  logic [9:0]  vp_p;

  vga_timing_gen u_dut_d (
    .clk_i(clk), .rst_i(rst), .pix_ce_i(pix_ce),
    .hsync_o(hs_d), .vsync_o(vs_d), .display_on_o(de_d),
    .hpos_o(hp_d), .vpos_o(vp_d), .line_start_o(ls_d), .frame_start_o(fs_d)
  );

  vga_timing_gen #(
    .H_DISPLAY(6), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .H_POL(1'b0), .V_POL(1'b0), .HW(4), .VW(4)
  ) u_dut_s (
    .clk_i(clk), .rst_i(rst), .pix_ce_i(pix_ce),
    .hsync_o(hs_s), .vsync_o(vs_s), .display_on_o(de_s),
    .hpos_o(hp_s), .vpos_o(vp_s), .line_start_o(ls_s), .frame_start_o(fs_s)
  );

  vga_timing_gen #(
    .H_DISPLAY(800), .H_FRONT(40), .H_SYNC(128), .H_BACK(88),
    .V_DISPLAY(600), .V_FRONT(1), .V_SYNC(4), .V_BACK(23),
    .H_POL(1'b1), .V_POL(1'b1), .HW(11), .VW(10)
  ) u_dut_p (
    .clk_i(clk), .rst_i(rst), .pix_ce_i(pix_ce),
    .hsync_o(hs_p), .vsync_o(vs_p), .display_on_o(de_p),
    .hpos_o(hp_p), .vpos_o(vp_p), .line_start_o(ls_p), .frame_start_o(fs_p)
  );

  logic [31:0] hpos_a [3];
  logic [31:0] vpos_a [3];
  logic        hs_a [3], vs_a [3], de_a [3], ls_a [3], fs_a [3];
  assign hpos_a[0] = 32'(hp_d);
  assign vpos_a[0] = 32'(vp_d);
  assign hpos_a[1] = 32'(hp_s);
  assign vpos_a[1] = 32'(vp_s);
  assign hpos_a[2] = 32'(hp_p);
  assign vpos_a[2] = 32'(vp_p);
  assign hs_a[0] = hs_d;  assign vs_a[0] = vs_d;  assign de_a[0] = de_d;
  assign hs_a[1] = hs_s;  assign vs_a[1] = vs_s;  assign de_a[1] = de_s;
  assign hs_a[2] = hs_p;  assign vs_a[2] = vs_p;  assign de_a[2] = de_p;
  assign ls_a[0] = ls_d;  assign fs_a[0] = fs_d;
  assign ls_a[1] = ls_s;  assign fs_a[1] = fs_s;
  assign ls_a[2] = ls_p;  assign fs_a[2] = fs_p;

  typedef struct {
    int hd, hf, hs, hb, vd, vf, vs, vb;
    bit hpol, vpol;
  } cfg_t;

  cfg_t cfg [3];
  int   mh [3];
  int   mv [3];
  bit   mvalid = 1'b0;
  int   tests = 0;
  int   fails = 0;
  bit   abort = 1'b0;
  int   ls_cnt = 0;
  int   fs_cnt = 0;
  logic pre_ls, pre_fs;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      if (fails >= 40) abort = 1'b1;
    end
  endtask

  // Position is a linear index into the frame; wrap is modulo the frame size.
  task automatic model_adv(int i, bit r, bit c);
    int ht, vt, lin;
    ht = cfg[i].hd + cfg[i].hf + cfg[i].hs + cfg[i].hb;
    vt = cfg[i].vd + cfg[i].vf + cfg[i].vs + cfg[i].vb;
    if (r) begin
      mh[i] = 0;
      mv[i] = 0;
    end else if (c) begin
      lin   = (mv[i] * ht + mh[i] + 1) % (ht * vt);
      mh[i] = lin % ht;
      mv[i] = lin / ht;
    end
  endtask

  function automatic logic [34:0] exp_state(int i);
    int  hlo, vlo;
    bit  ehs, evs, ede;
    hlo = cfg[i].hd + cfg[i].hf;
    vlo = cfg[i].vd + cfg[i].vf;
    ehs = (mh[i] >= hlo && mh[i] < hlo + cfg[i].hs) ? cfg[i].hpol : !cfg[i].hpol;
    evs = (mv[i] >= vlo && mv[i] < vlo + cfg[i].vs) ? cfg[i].vpol : !cfg[i].vpol;
    ede = (mh[i] < cfg[i].hd) && (mv[i] < cfg[i].vd);
    return {16'(mh[i]), 16'(mv[i]), ehs, evs, ede};
  endfunction

  function automatic logic [34:0] act_state(int i);
    return {hpos_a[i][15:0], vpos_a[i][15:0], hs_a[i], vs_a[i], de_a[i]};
  endfunction

  task automatic step(bit r, bit c);
    bit el, ef;
    rst    = r;
    pix_ce = c;
    #1;
    pre_ls = ls_a[1];
    pre_fs = fs_a[1];
    if (ls_a[0] === 1'b1) ls_cnt++;
    if (fs_a[1] === 1'b1) fs_cnt++;
    if (mvalid) begin
      for (int i = 0; i < 3; i++) begin
        el = STRB && c && !r && (mh[i] == 0);
        ef = el && (mv[i] == 0);
        chk($sformatf("strobe%0d{line,frame}", i), {ls_a[i], fs_a[i]}, {el, ef});
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_adv(i, r, c);
    if (r) mvalid = 1'b1;
    #1;
    if (mvalid) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("state%0d{h,v,hs,vs,de}", i), act_state(i), exp_state(i));
    end
  endtask

  typedef struct {
    bit r, c, el, ef;
    int h, v;
    bit hs, vs, de;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int cnt_d, hmin_d, hmax_d, cnt_p, hmin_p, hmax_p, hv;

    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0};
    cfg[1] = '{6, 2, 3, 2, 4, 1, 2, 2, 1'b0, 1'b0};
    cfg[2] = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1};

    // Small-geometry vectors: H 6/2/3/2 (sync cols 8..10), V 4/1/2/2.
    tbl[0]  = '{1, 1, 0, 0,  0, 0, 1, 1, 1};
    tbl[1]  = '{0, 0, 0, 0,  0, 0, 1, 1, 1};
    tbl[2]  = '{0, 1, 1, 1,  1, 0, 1, 1, 1};
    tbl[3]  = '{0, 0, 0, 0,  1, 0, 1, 1, 1};
    tbl[4]  = '{0, 1, 0, 0,  2, 0, 1, 1, 1};
    tbl[5]  = '{0, 1, 0, 0,  3, 0, 1, 1, 1};
    tbl[6]  = '{0, 1, 0, 0,  4, 0, 1, 1, 1};
    tbl[7]  = '{0, 1, 0, 0,  5, 0, 1, 1, 1};
    tbl[8]  = '{0, 1, 0, 0,  6, 0, 1, 1, 0};
    tbl[9]  = '{0, 1, 0, 0,  7, 0, 1, 1, 0};
    tbl[10] = '{0, 1, 0, 0,  8, 0, 0, 1, 0};
    tbl[11] = '{0, 0, 0, 0,  8, 0, 0, 1, 0};
    tbl[12] = '{0, 1, 0, 0,  9, 0, 0, 1, 0};
    tbl[13] = '{0, 1, 0, 0, 10, 0, 0, 1, 0};
    tbl[14] = '{0, 1, 0, 0, 11, 0, 1, 1, 0};
    tbl[15] = '{0, 1, 0, 0, 12, 0, 1, 1, 0};
    tbl[16] = '{0, 1, 0, 0,  0, 1, 1, 1, 1};
    tbl[17] = '{0, 1, 1, 0,  1, 1, 1, 1, 1};
    tbl[18] = '{1, 0, 0, 0,  0, 0, 1, 1, 1};
    tbl[19] = '{0, 1, 1, 1,  1, 0, 1, 1, 1};

    step(1'b1, 1'b1);

    for (int k = 0; k < 20; k++) begin
      if (abort) break;
      step(tbl[k].r, tbl[k].c);
      chk($sformatf("tbl%0d{line,frame}", k), {pre_ls, pre_fs},
          {STRB && tbl[k].el, STRB && tbl[k].ef});
      chk($sformatf("tbl%0d{h,v,hs,vs,de}", k), act_state(1),
          {16'(tbl[k].h), 16'(tbl[k].v), tbl[k].hs, tbl[k].vs, tbl[k].de});
    end

    // Full first line on the default and the high-polarity geometries.
    step(1'b1, 1'b0);
    cnt_d = 0; hmin_d = 1 << 20; hmax_d = -1;
    cnt_p = 0; hmin_p = 1 << 20; hmax_p = -1;
    for (int k = 0; k < 1100; k++) begin
      if (abort) break;
      step(1'b0, 1'b1);
      hv = int'(hpos_a[0]);
      if (hs_a[0] === 1'b0) begin
        cnt_d++;
        if (hv < hmin_d) hmin_d = hv;
        if (hv > hmax_d) hmax_d = hv;
      end
      hv = int'(hpos_a[2]);
      if (hv > hmax_p) hmax_p = hv;
      if (hs_a[2] === 1'b1) begin
        cnt_p++;
        if (hv < hmin_p) hmin_p = hv;
      end
    end
    chk("hsync_low_cycles_640", 64'(cnt_d), 64'd96);
    chk("hsync_first_col_640", 64'(hmin_d), 64'd656);
    chk("hsync_last_col_640", 64'(hmax_d), 64'd751);
    chk("hsync_high_cycles_800", 64'(cnt_p), 64'd128);
    chk("hsync_first_col_800", 64'(hmin_p), 64'd840);
    chk("hpos_max_800", 64'(hmax_p), 64'd1055);

    // Mid-line reset with the pixel enable still high.
    chk("pre_reset_hpos", 64'(hpos_a[0]), 64'd300);
    step(1'b1, 1'b1);
    chk("reset_state_640", 64'(act_state(0)), {16'd0, 16'd0, 1'b1, 1'b1, 1'b1});

    // Half-rate pixel enable: one line takes 1600 clocks.
    step(1'b1, 1'b0);
    ls_cnt = 0;
    for (int k = 0; k < 1600; k++) begin
      if (abort) break;
      step(1'b0, (k % 2) == 0);
    end
    chk("halfrate_hpos", 64'(hpos_a[0]), 64'd0);
    chk("halfrate_vpos", 64'(vpos_a[0]), 64'd1);
    chk("halfrate_line_strobes", 64'(ls_cnt), 64'(STRB));
    step(1'b0, 1'b1);
    chk("halfrate_line_strobes_next", 64'(ls_cnt), 64'(2 * int'(STRB)));

    // Frame wrap on the small geometry: last pixel of the last line.
    step(1'b1, 1'b0);
    for (int k = 0; k < 116; k++) begin
      if (abort) break;
      step(1'b0, 1'b1);
    end
    chk("last_pixel_hpos", 64'(hpos_a[1]), 64'd12);
    chk("last_pixel_vpos", 64'(vpos_a[1]), 64'd8);
    fs_cnt = 0;
    step(1'b0, 1'b1);
    chk("frame_wrap{h,v,de}", {hpos_a[1][15:0], vpos_a[1][15:0], de_a[1]}, {16'd0, 16'd0, 1'b1});
    step(1'b0, 1'b1);
    chk("frame_start_after_wrap", 64'(fs_cnt), 64'(STRB));

    // Random enable and occasional reset against the model.
    for (int k = 0; k < 4000; k++) begin
      if (abort) break;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
